cache_ctrl: RTL and testbench

//  Two-way set-associative, write-through, no-write-allocate data cache between the MEM stage and SRAM_Controller64.

---
 rtl/cache_ctrl_pkg.sv | 30 +++
 rtl/cache_mem.sv | 82 ++++++++
 rtl/cache_ctrl.sv | 121 ++++++++++++
 tb/tb_cache_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the two-way set-associative write-through data cache.
// Holds the geometry constants, the controller state encoding and the
// address field helpers (index / tag / word select).
package cache_ctrl_pkg;

  localparam int SETS    = 64;
  localparam int IDX_W   = 6;
  localparam int TAG_W   = 10;
  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] a);
    return a[8:3];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[18:9];
  endfunction

  function automatic logic addr_word(input logic [31:0] a);
    return a[2];
  endfunction

endpackage

// File: rtl/cache_mem.sv
// Tag/valid/data/LRU storage for the two-way cache.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (clears valid and LRU)
//   index/tag/word_sel  lookup address fields
//   hit, hit_word   combinational lookup result (word of the hitting way)
//   touch           read hit: LRU points away from the hitting way
//   fill, fill_block    write a block into the LRU way, set valid/tag, flip LRU
//   update, update_word write-through hit: overwrite the hit word
module cache_mem
  import cache_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   index,
  input  logic [TAG_W-1:0]   tag,
  input  logic               word_sel,
  output logic               hit,
  output logic [WORD_W-1:0]  hit_word,
  input  logic               touch,
  input  logic               fill,
  input  logic [BLOCK_W-1:0] fill_block,
  input  logic               update,
  input  logic [WORD_W-1:0]  update_word
);

  logic [SETS-1:0]    valid0, valid1;
  // lru[i] = 1 means way0 is least recently used in set i.
  logic [SETS-1:0]    lru;
  logic [TAG_W-1:0]   tag0  [SETS];
  logic [TAG_W-1:0]   tag1  [SETS];
  logic [BLOCK_W-1:0] data0 [SETS];
  logic [BLOCK_W-1:0] data1 [SETS];

  logic               hit0, hit1, victim1;
  logic [BLOCK_W-1:0] blk;

  always_comb begin
    hit0     = valid0[index] && (tag0[index] == tag);
    hit1     = valid1[index] && (tag1[index] == tag);
    hit      = hit0 || hit1;
    blk      = hit1 ? data1[index] : data0[index];
    hit_word = word_sel ? blk[63:32] : blk[31:0];
    victim1  = ~lru[index];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else if (fill) begin
      if (victim1) valid1[index] <= 1'b1;
      else         valid0[index] <= 1'b1;
      lru[index] <= ~lru[index];
    end else if (touch) begin
      // Hitting way becomes MRU, so the other way is now the victim.
      lru[index] <= hit1;
    end
  end

  // Tag and data contents are only meaningful under valid, so no reset.
  always_ff @(posedge clk) begin
    if (fill) begin
      if (victim1) begin
        tag1[index]  <= tag;
        data1[index] <= fill_block;
      end else begin
        tag0[index]  <= tag;
        data0[index] <= fill_block;
      end
    end else if (update && hit) begin
      if (hit1) begin
        if (word_sel) data1[index][63:32] <= update_word;
        else          data1[index][31:0]  <= update_word;
      end else begin
        if (word_sel) data0[index][63:32] <= update_word;
        else          data0[index][31:0]  <= update_word;
      end
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Write-through, no-write-allocate data cache controller between the MEM
// stage and a 64-bit SRAM controller. Read hits complete in the same cycle;
// read misses fetch a block and fill the LRU way; all writes go to SRAM.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   addr, write_data    pipeline request (held stable while ready=0)
//   MEM_R_EN, MEM_W_EN  load / store request (both high = store)
//   read_data, ready    load result and stall control
//   sram_*              SRAM controller request/response
//   fsm_state           controller state, for observation
// Handshake: a request is accepted while ready=1 in IDLE; a request that
// needs SRAM holds its enable until the single-cycle sram_ready pulse, and
// ready=1 in that pulse cycle marks completion.
module cache_ctrl
  import cache_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        addr,
  input  logic [WORD_W-1:0]  write_data,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  output logic [WORD_W-1:0]  read_data,
  output logic               ready,
  output logic [31:0]        sram_addr,
  output logic [WORD_W-1:0]  sram_write_data,
  output logic               sram_write_en,
  output logic               sram_read_en,
  input  logic [BLOCK_W-1:0] sram_read_data,
  input  logic               sram_ready,
  output state_t             fsm_state
);

  state_t      state, next_state;
  logic        hit, touch, fill, update;
  logic [WORD_W-1:0] hit_word;
  logic        read_req, write_req;

  assign sram_addr       = addr;
  assign sram_write_data = write_data;
  assign fsm_state       = state;
  assign write_req       = MEM_W_EN;
  assign read_req        = MEM_R_EN && !MEM_W_EN;

  cache_mem u_mem (
    .clk         (clk),
    .rst         (rst),
    .index       (addr_index(addr)),
    .tag         (addr_tag(addr)),
    .word_sel    (addr_word(addr)),
    .hit         (hit),
    .hit_word    (hit_word),
    .touch       (touch),
    .fill        (fill),
    .fill_block  (sram_read_data),
    .update      (update),
    .update_word (write_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (write_req)            next_state = WRITE;
        else if (read_req && !hit) next_state = READ_MISS;
      end
      READ_MISS, WRITE: if (sram_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready         = 1'b1;
    read_data     = '0;
    sram_read_en  = 1'b0;
    sram_write_en = 1'b0;
    touch         = 1'b0;
    fill          = 1'b0;
    update        = 1'b0;
    // While reset is held the outputs sit at their idle values even if the
    // pipeline keeps a request asserted.
    if (rst) begin
      case (state)
        IDLE: begin
          if (write_req) begin
            sram_write_en = 1'b1;
            ready         = 1'b0;
            update        = hit;
          end else if (read_req) begin
            if (hit) begin
              read_data = hit_word;
              touch     = 1'b1;
            end else begin
              sram_read_en = 1'b1;
              ready        = 1'b0;
            end
          end
        end
        READ_MISS: begin
          sram_read_en = 1'b1;
          ready        = sram_ready;
          if (sram_ready) begin
            read_data = addr_word(addr) ? sram_read_data[63:32] : sram_read_data[31:0];
            fill      = 1'b1;
          end
        end
        WRITE: begin
          sram_write_en = 1'b1;
          ready         = sram_ready;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;
  import cache_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] addr = '0, write_data = '0;
  logic        MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
  logic [31:0] read_data, sram_addr, sram_write_data;
  logic        ready, sram_write_en, sram_read_en;
  logic [63:0] sram_read_data;
  logic        sram_ready;
  state_t      fsm_state;

  cache_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .addr            (addr),
    .write_data      (write_data),
    .MEM_R_EN        (MEM_R_EN),
    .MEM_W_EN        (MEM_W_EN),
    .read_data       (read_data),
    .ready           (ready),
    .sram_addr       (sram_addr),
    .sram_write_data (sram_write_data),
    .sram_write_en   (sram_write_en),
    .sram_read_en    (sram_read_en),
    .sram_read_data  (sram_read_data),
    .sram_ready      (sram_ready),
    .fsm_state       (fsm_state)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] sram_mem[logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 32'd0;
  endfunction

  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- SRAM model: sram_ready ~5 cycles after enable ----------------
  initial begin
    bit busy;
    int cnt;
    logic [31:0] wa;
    busy = 0;
    cnt = 0;
    sram_ready = 1'b0;
    sram_read_data = '0;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        busy = 0;
        sram_ready = 1'b0;
      end else if (sram_ready) begin
        sram_ready = 1'b0;
        busy = 0;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          sram_ready = 1'b1;
          wa = {sram_addr[31:2], 2'b00};
          if (sram_write_en) sram_mem[wa] = sram_write_data;
          else sram_read_data = {sram_rd(wa | 32'h4), sram_rd(wa & ~32'h4)};
        end
      end else if (sram_read_en || sram_write_en) begin
        busy = 1;
        cnt = 4;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input bit exp_hit, input bit chk_hit, input string name);
    int stall;
    bit saw_rd, saw_wr, done;
    logic [31:0] got;
    stall = 0; saw_rd = 0; saw_wr = 0; done = 0; got = '0;
    addr = a; write_data = wd; MEM_W_EN = wr; MEM_R_EN = !wr;
    if (wr) ref_mem[a] = wd;
    else exp_q.push_back(ref_rd(a));
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk); #2;
      saw_rd |= sram_read_en;
      saw_wr |= sram_write_en;
      if (ready) begin
        done = 1;
        got = read_data;
      end else stall++;
    end
    check({name, " done"}, 32'(done), 32'd1);
    if (!wr && exp_q.size() > 0) begin
      if (done) check({name, " data"}, got, exp_q.pop_front());
      else void'(exp_q.pop_front());
    end
    if (done) begin
      if (wr) begin
        check({name, " stalled"}, 32'(stall > 0), 32'd1);
        check({name, " wr_en"}, 32'(saw_wr), 32'd1);
        check({name, " no rd_en"}, 32'(saw_rd), 32'd0);
      end else if (chk_hit) begin
        check({name, " hit"}, 32'(stall == 0), 32'(exp_hit));
        check({name, " rd_en"}, 32'(saw_rd), 32'(!exp_hit));
      end
    end
    @(posedge clk); #1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    bit          hit;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit hit);
    vec_t v;
    v.wr = wr; v.a = a; v.d = d; v.hit = hit;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] pool[6];
    bit seen;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    check("reset ready", 32'(ready), 32'd1);
    check("reset rd_en", 32'(sram_read_en), 32'd0);
    check("reset wr_en", 32'(sram_write_en), 32'd0);
    check("reset read_data", read_data, 32'd0);
    check("reset state", 32'(fsm_state), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Write-through / no-allocate / fill / hit / LRU sequence.
    // Set 0 holds blocks 1024, 1536, 2048 (tags 2, 3, 4).
    add_vec(1, 1024, 97690, 0);
    add_vec(1, 1028, 97685, 0);
    add_vec(1, 1036, 31415, 0);
    add_vec(0, 1036, 0, 0);      // cold miss, fills block 1032
    add_vec(0, 1036, 0, 1);
    add_vec(0, 1032, 0, 1);      // other word of same block
    add_vec(0, 1024, 0, 0);      // writes did not allocate
    add_vec(0, 1028, 0, 1);
    add_vec(1, 1024, 5, 1);      // write hit updates cache
    add_vec(0, 1024, 0, 1);
    add_vec(1, 1540, 111, 0);
    add_vec(1, 2048, 222, 0);
    add_vec(0, 1540, 0, 0);      // second way of set 0
    add_vec(0, 2048, 0, 0);      // evicts 1024 (least recent)
    add_vec(0, 1540, 0, 1);
    add_vec(0, 1024, 0, 0);      // evicts 2048
    add_vec(0, 1536, 0, 1);
    add_vec(0, 2048, 0, 0);      // evicts 1024 again
    foreach (vecs[i])
      do_req(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].hit, 1'b1, $sformatf("vec%0d", i));

    // Random reads: data only, hit/miss depends on the draw order.
    pool[0] = 1024; pool[1] = 1028; pool[2] = 1536;
    pool[3] = 1540; pool[4] = 2048; pool[5] = 1036;
    for (int i = 0; i < 8; i++)
      do_req(1'b0, pool[$urandom_range(0, 5)], 32'd0, 1'b0, 1'b0, $sformatf("rnd%0d", i));

    // Request dropped mid-miss: SRAM read still runs to completion.
    addr = 4096; MEM_R_EN = 1'b1;
    @(negedge clk); @(negedge clk); #2;
    check("drop rd_en before", 32'(sram_read_en), 32'd1);
    @(posedge clk); #1;
    MEM_R_EN = 1'b0;
    @(negedge clk); #2;
    check("drop rd_en held", 32'(sram_read_en), 32'd1);
    check("drop stalled", 32'(ready), 32'd0);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #2;
      if (sram_ready) seen = 1;
    end
    check("drop sram_ready seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); #2;
    check("drop idle", 32'(fsm_state), 32'(IDLE));
    check("drop ready", 32'(ready), 32'd1);
    check("drop rd_en low", 32'(sram_read_en), 32'd0);
    @(posedge clk); #1;

    // Reset mid-miss.
    addr = 8192; MEM_R_EN = 1'b1;
    @(negedge clk); @(negedge clk); #2;
    check("rstmid rd_en before", 32'(sram_read_en), 32'd1);
    rst = 1'b0;
    #1;
    check("rstmid rd_en", 32'(sram_read_en), 32'd0);
    check("rstmid ready", 32'(ready), 32'd1);
    check("rstmid read_data", read_data, 32'd0);
    check("rstmid state", 32'(fsm_state), 32'(IDLE));
    @(posedge clk); #1;
    MEM_R_EN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 1036, 32'd0, 1'b0, 1'b1, "post_rst miss");
    do_req(1'b0, 1036, 32'd0, 1'b1, 1'b1, "post_rst hit");

    check("exp_q drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
